dprintf_mux: RTL and testbench
==============================

Name: dprintf_mux

Overview:
- Parametrised N-channel debug-printf request concentrator.
- Sits between several dprintf request sources (subsystems, test harnesses) and a single downstream dprintf formatter.
- Arbitrates with a round-robin or fixed-priority policy, registers the winning request, forwards it with the req/ack protocol, and returns the ack to the winning channel only.
- Previously only one source could drive a dprintf formatter; this block removes that limit.

Parameters:
- NUM_CHANNELS, 4, number of requesting channels (2..16).
- ADDR_WIDTH, 16, width of the dprintf address field.
- ARB_MODE, 0, 0 = round robin; 1 = fixed priority (lowest index wins).

Ports:
- clk  input  1  clock.
- clk__enable  input  1  clock enable; all state advances only when high.
- reset_n  input  1  asynchronous active-low reset.
- ch_req__valid  input  NUM_CHANNELS  per-channel request valid.
- ch_req__address  input  NUM_CHANNELS*ADDR_WIDTH  per-channel address; channel i occupies slice i.
- ch_req__data_0..ch_req__data_3  input  NUM_CHANNELS*64 each  per-channel data words; channel i occupies slice i.
- ch_ack  output  NUM_CHANNELS  per-channel one-cycle ack pulse.
- dprintf_req__valid  output  1  downstream request valid.
- dprintf_req__address  output  ADDR_WIDTH  downstream address.
- dprintf_req__data_0..dprintf_req__data_3  output  64 each  downstream data.
- dprintf_ack  input  1  downstream ack, one-cycle pulse.
- grant_channel  output  clog2(NUM_CHANNELS)  index of the channel currently latched (debug).

Behaviour:
- Single clock, reset asynchronous active-low.
- Reset values: ch_ack=0, dprintf_req__valid=0, address/data=0, grant_channel=0, state=IDLE, rr_last=NUM_CHANNELS-1 (channel 0 has first priority).
- Protocol, both sides: requester holds valid and payload stable until it sees ack; ack is high for exactly one cycle; requester samples ack and drops or replaces valid at that edge.
- State IDLE:
  - If any ch_req__valid is set: select a winner. ARB_MODE=0 searches from rr_last+1 upward with wrap; ARB_MODE=1 takes the lowest set index.
  - Latch the winner's address/data into the holding register, set grant_channel, set dprintf_req__valid=1, go to BUSY.
  - Latency is 1 cycle from a valid sampled in IDLE to downstream valid.
- State BUSY:
  - Holds the downstream outputs stable. Later changes on the granted channel's inputs are ignored; the latched copy is used.
  - On dprintf_ack=1: dprintf_req__valid goes to 0, ch_ack[grant] goes to 1, rr_last=grant, go to ACK.
- State ACK:
  - ch_ack returns to 0 and the state goes to IDLE.
  - This cycle ensures the granted requester has already dropped valid before re-arbitration, so no double issue occurs.
- Minimum period is 3 cycles per message; the downstream ack may arrive at the earliest 1 cycle after valid.
- dprintf_ack while not in BUSY is ignored and raises an assertion error.
- A channel dropping valid before its ack is a protocol violation; the latched request still completes and an assertion fires.
- Simultaneous requests: exactly one is granted; the others wait. Under round robin with all channels requesting, grants rotate 0,1,2,...,N-1,0; no channel waits more than N-1 grants.
- Fixed priority may starve high-index channels; this is by design.
- clk__enable=0 freezes all state, including a pending ack pulse, which is extended until the next enabled edge.
- reset_n asserted mid-transaction: immediate return to reset values. An in-flight request is dropped with no ack, and requesters re-present it after reset.

Decomposition:
- Shared package dprintf_pkg: t_dprintf_req (valid, address, data_0..3), t_dprintf_byte, DPRINTF_DATA_WORDS=4, DPRINTF_WORD_WIDTH=64, and the ARB_MODE encodings.
- One sub-module, dprintf_rr_arbiter:
  - Parametrised N-way combinational round-robin/priority pick.
  - Inputs: req vector, rr_last, mode. Outputs: one-hot grant, grant index, any.
  - Reusable by later dprintf fan-in blocks.

Test Plan:
- Single request: ch 2 requests address 0x0040, data_0=0x1122334455667788. Required: downstream valid 1 cycle later with identical payload; an ack at cycle +3 gives ch_ack=4'b0100 for exactly one cycle; no reissue.
- All 4 channels request continuously, ARB_MODE=0, downstream acks 2 cycles after valid. Required: grant order 0,1,2,3,0; each ch_ack pulses once per grant.
- Same stimulus with ARB_MODE=1. Required: channel 0 is granted every time and channels 1–3 are never acked while ch 0 stays valid.
- Ch 1 changes data_0 from 0xAAAA to 0xBBBB while in BUSY. Required: downstream data_0 stays 0xAAAA until ack.
- reset_n is pulsed low while BUSY on ch 3. Required: outputs 0 asynchronously, no ch_ack, and after release ch 0 wins first when chs 0 and 3 both request.
- clk__enable held low for 5 cycles during ACK. Required: ch_ack[grant] stays 1 throughout and clears on the first enabled edge.

Source files
------------

// File: rtl/dprintf_pkg.sv
// Shared types and constants for the dprintf request fan-in blocks.
package dprintf_pkg;

    localparam int DPRINTF_DATA_WORDS = 4;
    localparam int DPRINTF_WORD_WIDTH = 64;
    localparam int DPRINTF_ADDR_WIDTH = 16;

    localparam int ARB_ROUND_ROBIN    = 0;
    localparam int ARB_FIXED_PRIORITY = 1;

    typedef logic [7:0] t_dprintf_byte;
    typedef logic [DPRINTF_DATA_WORDS-1:0][DPRINTF_WORD_WIDTH-1:0] t_dprintf_data;

    typedef struct packed {
        logic                          valid;
        logic [DPRINTF_ADDR_WIDTH-1:0] address;
        t_dprintf_data                 data;
    } t_dprintf_req;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ACK
    } t_mux_state;

endpackage

// File: rtl/dprintf_rr_arbiter.sv
// Combinational N-way pick: round robin after rr_last, or lowest index when mode is set.
module dprintf_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] rr_last,
    input  logic                 mode,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = mode ? IDX_W'(i) : IDX_W'((int'(rr_last) + 1 + i) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/dprintf_mux.sv
// N-channel dprintf request concentrator: arbitrates, registers the winner and
// forwards it downstream with req/ack, returning the ack to the winner only.
module dprintf_mux
    import dprintf_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_WIDTH   = 16,
    parameter int ARB_MODE     = ARB_ROUND_ROBIN
) (
    input  logic                                     clk,
    input  logic                                     clk__enable,
    input  logic                                     reset_n,
    input  logic [NUM_CHANNELS-1:0]                  ch_req__valid,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]       ch_req__address,
    input  logic [NUM_CHANNELS*DPRINTF_WORD_WIDTH-1:0] ch_req__data_0,
    input  logic [NUM_CHANNELS*DPRINTF_WORD_WIDTH-1:0] ch_req__data_1,
    input  logic [NUM_CHANNELS*DPRINTF_WORD_WIDTH-1:0] ch_req__data_2,
    input  logic [NUM_CHANNELS*DPRINTF_WORD_WIDTH-1:0] ch_req__data_3,
    output logic [NUM_CHANNELS-1:0]                  ch_ack,
    output logic                                     dprintf_req__valid,
    output logic [ADDR_WIDTH-1:0]                    dprintf_req__address,
    output logic [DPRINTF_WORD_WIDTH-1:0]            dprintf_req__data_0,
    output logic [DPRINTF_WORD_WIDTH-1:0]            dprintf_req__data_1,
    output logic [DPRINTF_WORD_WIDTH-1:0]            dprintf_req__data_2,
    output logic [DPRINTF_WORD_WIDTH-1:0]            dprintf_req__data_3,
    input  logic                                     dprintf_ack,
    output logic [$clog2(NUM_CHANNELS)-1:0]          grant_channel
);

    localparam int IDX_W = $clog2(NUM_CHANNELS);
    localparam int WW    = DPRINTF_WORD_WIDTH;

    t_mux_state              state_q, state_d;
    logic [IDX_W-1:0]        rr_last_q, rr_last_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic                    valid_q, valid_d;
    logic [NUM_CHANNELS-1:0] ack_q, ack_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    t_dprintf_data           data_q, data_d;

    logic [NUM_CHANNELS-1:0] arb_grant;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_any;
    logic [ADDR_WIDTH-1:0]   pick_addr;
    t_dprintf_data           pick_data;

    dprintf_rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
        .req       (ch_req__valid),
        .rr_last   (rr_last_q),
        .mode      (ARB_MODE == ARB_FIXED_PRIORITY),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // One-hot AND-OR select keeps the payload mux flat regardless of channel count.
    always_comb begin
        pick_addr = '0;
        pick_data = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (arb_grant[i]) begin
                pick_addr    |= ch_req__address[i*ADDR_WIDTH +: ADDR_WIDTH];
                pick_data[0] |= ch_req__data_0[i*WW +: WW];
                pick_data[1] |= ch_req__data_1[i*WW +: WW];
                pick_data[2] |= ch_req__data_2[i*WW +: WW];
                pick_data[3] |= ch_req__data_3[i*WW +: WW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        ack_d     = ack_q;
        addr_d    = addr_q;
        data_d    = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    addr_d  = pick_addr;
                    data_d  = pick_data;
                    grant_d = arb_idx;
                    valid_d = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (dprintf_ack) begin
                    valid_d        = 1'b0;
                    ack_d          = '0;
                    ack_d[grant_q] = 1'b1;
                    rr_last_d      = grant_q;
                    state_d        = ST_ACK;
                end
            end
            // The requester drops valid on this edge, so re-arbitration waits one cycle.
            ST_ACK: begin
                ack_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            rr_last_q <= IDX_W'(NUM_CHANNELS - 1);
            grant_q   <= '0;
            valid_q   <= 1'b0;
            ack_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
        end else if (clk__enable) begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            ack_q     <= ack_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign ch_ack               = ack_q;
    assign dprintf_req__valid   = valid_q;
    assign dprintf_req__address = addr_q;
    assign dprintf_req__data_0  = data_q[0];
    assign dprintf_req__data_1  = data_q[1];
    assign dprintf_req__data_2  = data_q[2];
    assign dprintf_req__data_3  = data_q[3];
    assign grant_channel        = grant_q;

    a_ack_only_when_busy: assert property (@(posedge clk) disable iff (!reset_n)
        (clk__enable && dprintf_ack) |-> (state_q == ST_BUSY));

    a_granted_holds_valid: assert property (@(posedge clk) disable iff (!reset_n)
        (clk__enable && state_q == ST_BUSY) |-> ch_req__valid[grant_q]);

endmodule

// File: tb/tb_dprintf_mux.sv
// Self-checking bench for dprintf_mux: arbitration table, directed corner cases,
// and a randomized run against a transaction-level reference model.
module tb_dprintf_mux;
    import dprintf_pkg::*;

    localparam int N  = 4;
    localparam int AW = 16;

    logic clk   = 1'b0;
    logic en    = 1'b1;
    logic rst_n = 1'b0;
    logic [1:0] act = 2'b00;

    logic [N-1:0]    drv_valid = '0;
    logic [N*AW-1:0] drv_addr  = '0;
    logic [N*64-1:0] drv_d0 = '0, drv_d1 = '0, drv_d2 = '0, drv_d3 = '0;

    logic [N-1:0]  vin      [2];
    logic          dp_ack   [2];
    logic [N-1:0]  ch_ack_o [2];
    logic          dp_valid [2];
    logic [AW-1:0] dp_addr  [2];
    logic [63:0]   dp_d0 [2], dp_d1 [2], dp_d2 [2], dp_d3 [2];
    logic [1:0]    grant_o  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign vin[0] = drv_valid & {N{act[0]}};
    assign vin[1] = drv_valid & {N{act[1]}};

    dprintf_mux #(.NUM_CHANNELS(N), .ADDR_WIDTH(AW), .ARB_MODE(0)) dut_rr (
        .clk(clk), .clk__enable(en), .reset_n(rst_n),
        .ch_req__valid(vin[0]), .ch_req__address(drv_addr),
        .ch_req__data_0(drv_d0), .ch_req__data_1(drv_d1),
        .ch_req__data_2(drv_d2), .ch_req__data_3(drv_d3),
        .ch_ack(ch_ack_o[0]), .dprintf_req__valid(dp_valid[0]),
        .dprintf_req__address(dp_addr[0]),
        .dprintf_req__data_0(dp_d0[0]), .dprintf_req__data_1(dp_d1[0]),
        .dprintf_req__data_2(dp_d2[0]), .dprintf_req__data_3(dp_d3[0]),
        .dprintf_ack(dp_ack[0]), .grant_channel(grant_o[0])
    );

    dprintf_mux #(.NUM_CHANNELS(N), .ADDR_WIDTH(AW), .ARB_MODE(1)) dut_fp (
        .clk(clk), .clk__enable(en), .reset_n(rst_n),
        .ch_req__valid(vin[1]), .ch_req__address(drv_addr),
        .ch_req__data_0(drv_d0), .ch_req__data_1(drv_d1),
        .ch_req__data_2(drv_d2), .ch_req__data_3(drv_d3),
        .ch_ack(ch_ack_o[1]), .dprintf_req__valid(dp_valid[1]),
        .dprintf_req__address(dp_addr[1]),
        .dprintf_req__data_0(dp_d0[1]), .dprintf_req__data_1(dp_d1[1]),
        .dprintf_req__data_2(dp_d2[1]), .dprintf_req__data_3(dp_d3[1]),
        .dprintf_ack(dp_ack[1]), .grant_channel(grant_o[1])
    );

    typedef struct {
        int         prime;   // channel served first to move the round-robin pointer, -1 = none
        logic [3:0] mask;
        int         exp_rr;
        int         exp_fp;
    } t_vec;

    t_vec vecs [8];

    logic [N-1:0]  r_vld, r_vprev, r_exp_ca;
    logic [15:0]   r_pa [N];
    logic [63:0]   r_pd [N][4];
    bit            r_prev_v, r_prev_ca, r_ack_drv, r_sched, r_exp_v, r_found;
    int            r_cnt, r_cur, r_last, r_issued, r_acked;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] chaddr(input int ch);
        return 16'h1000 + 16'(ch) * 16'h0111;
    endfunction

    function automatic logic [63:0] chdata(input int ch, input int w);
        return 64'hC0DE_0000_0000_0000 + 64'(ch * 16 + w);
    endfunction

    task automatic load(input int ch, input logic [15:0] a, input logic [63:0] w0,
                        input logic [63:0] w1, input logic [63:0] w2, input logic [63:0] w3);
        drv_addr[ch*AW +: AW] = a;
        drv_d0[ch*64 +: 64]   = w0;
        drv_d1[ch*64 +: 64]   = w1;
        drv_d2[ch*64 +: 64]   = w2;
        drv_d3[ch*64 +: 64]   = w3;
    endtask

    task automatic load_all();
        for (int ch = 0; ch < N; ch++)
            load(ch, chaddr(ch), chdata(ch, 0), chdata(ch, 1), chdata(ch, 2), chdata(ch, 3));
    endtask

    task automatic do_reset(input logic [1:0] which);
        rst_n     = 1'b0;
        drv_valid = '0;
        dp_ack[0] = 1'b0;
        dp_ack[1] = 1'b0;
        en        = 1'b1;
        act       = which;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // All channels request continuously; downstream acks two cycles after valid.
    task automatic run_continuous(input int m);
        int w;
        int exp;
        do_reset(m == 0 ? 2'b01 : 2'b10);
        load_all();
        drv_valid = '1;
        for (int g = 0; g < 5; g++) begin
            w = 0;
            while (!dp_valid[m] && w < 10) begin
                tick();
                w++;
            end
            exp = (m == 0) ? g % N : 0;
            check($sformatf("cont m%0d g%0d valid", m, g), dp_valid[m], 1);
            check($sformatf("cont m%0d g%0d grant", m, g), grant_o[m], exp);
            check($sformatf("cont m%0d g%0d addr", m, g), dp_addr[m], chaddr(exp));
            tick();
            dp_ack[m] = 1'b1;
            tick();
            check($sformatf("cont m%0d g%0d ch_ack", m, g), ch_ack_o[m], N'(1) << exp);
            dp_ack[m] = 1'b0;
            tick();
            check($sformatf("cont m%0d g%0d ch_ack clear", m, g), ch_ack_o[m], 0);
        end
    endtask

    initial begin
        vecs[0] = '{-1, 4'b1111, 0, 0};
        vecs[1] = '{-1, 4'b1010, 1, 1};
        vecs[2] = '{ 0, 4'b1111, 1, 0};
        vecs[3] = '{ 1, 4'b0011, 0, 0};
        vecs[4] = '{ 2, 4'b1001, 3, 0};
        vecs[5] = '{ 3, 4'b1100, 2, 2};
        vecs[6] = '{ 3, 4'b1000, 3, 3};
        vecs[7] = '{ 2, 4'b0100, 2, 2};

        // Reset state
        do_reset(2'b11);
        tick();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("reset m%0d valid", m), dp_valid[m], 0);
            check($sformatf("reset m%0d ch_ack", m), ch_ack_o[m], 0);
            check($sformatf("reset m%0d grant", m), grant_o[m], 0);
            check($sformatf("reset m%0d addr", m), dp_addr[m], 0);
            check($sformatf("reset m%0d data_3", m), dp_d3[m], 0);
        end

        // Arbitration table, both policies side by side
        for (int v = 0; v < 8; v++) begin
            do_reset(2'b11);
            load_all();
            if (vecs[v].prime >= 0) begin
                drv_valid = N'(1) << vecs[v].prime;
                tick();
                dp_ack[0] = 1'b1;
                dp_ack[1] = 1'b1;
                tick();
                dp_ack[0] = 1'b0;
                dp_ack[1] = 1'b0;
                drv_valid = '0;
                tick();
            end
            drv_valid = vecs[v].mask;
            tick();
            check($sformatf("vec%0d rr grant", v), grant_o[0], vecs[v].exp_rr);
            check($sformatf("vec%0d fp grant", v), grant_o[1], vecs[v].exp_fp);
            check($sformatf("vec%0d rr addr", v), dp_addr[0], chaddr(vecs[v].exp_rr));
            check($sformatf("vec%0d fp data_1", v), dp_d1[1], chdata(vecs[v].exp_fp, 1));
        end

        // Single request on channel 2
        do_reset(2'b01);
        load(2, 16'h0040, 64'h1122334455667788, 64'h1, 64'h2, 64'h3);
        drv_valid = 4'b0100;
        tick();
        check("single valid", dp_valid[0], 1);
        check("single addr", dp_addr[0], 16'h0040);
        check("single data_0", dp_d0[0], 64'h1122334455667788);
        check("single grant", grant_o[0], 2);
        tick();
        tick();
        check("single held valid", dp_valid[0], 1);
        check("single no early ack", ch_ack_o[0], 0);
        dp_ack[0] = 1'b1;
        tick();
        check("single ch_ack", ch_ack_o[0], 4'b0100);
        check("single valid drop", dp_valid[0], 0);
        dp_ack[0] = 1'b0;
        drv_valid = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("single ack one cycle", ch_ack_o[0], 0);
            check("single no reissue", dp_valid[0], 0);
        end

        run_continuous(0);
        run_continuous(1);

        // Payload change on the granted channel while busy is ignored
        do_reset(2'b01);
        load(1, 16'h0011, 64'hAAAA, 64'h0, 64'h0, 64'h0);
        drv_valid = 4'b0010;
        tick();
        check("hold data_0 latched", dp_d0[0], 64'hAAAA);
        load(1, 16'h0011, 64'hBBBB, 64'h0, 64'h0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold data_0 stable", dp_d0[0], 64'hAAAA);
        end
        dp_ack[0] = 1'b1;
        tick();
        check("hold ch_ack", ch_ack_o[0], 4'b0010);
        dp_ack[0] = 1'b0;
        drv_valid = '0;
        tick();

        // Asynchronous reset while busy on channel 3
        do_reset(2'b01);
        load_all();
        drv_valid = 4'b1000;
        tick();
        check("areset busy grant", grant_o[0], 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("areset valid", dp_valid[0], 0);
        check("areset addr", dp_addr[0], 0);
        check("areset data_0", dp_d0[0], 0);
        check("areset grant", grant_o[0], 0);
        check("areset ch_ack", ch_ack_o[0], 0);
        drv_valid = 4'b1001;
        tick();
        check("areset held ch_ack", ch_ack_o[0], 0);
        #3;
        rst_n = 1'b1;
        tick();
        check("areset first winner", grant_o[0], 0);
        check("areset first addr", dp_addr[0], chaddr(0));
        dp_ack[0] = 1'b1;
        tick();
        check("areset ch_ack", ch_ack_o[0], 4'b0001);
        dp_ack[0] = 1'b0;
        drv_valid = 4'b1000;
        tick();
        tick();
        check("areset next winner", grant_o[0], 3);
        dp_ack[0] = 1'b1;
        tick();
        dp_ack[0] = 1'b0;
        drv_valid = '0;
        tick();

        // Clock enable low during the ack cycle stretches the pulse
        do_reset(2'b01);
        load_all();
        drv_valid = 4'b0100;
        tick();
        dp_ack[0] = 1'b1;
        tick();
        check("enable ch_ack", ch_ack_o[0], 4'b0100);
        dp_ack[0] = 1'b0;
        drv_valid = '0;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("enable ch_ack frozen", ch_ack_o[0], 4'b0100);
        end
        en = 1'b1;
        tick();
        check("enable ch_ack clear", ch_ack_o[0], 0);

        // Randomized traffic against a transaction-level model
        do_reset(2'b01);
        r_vld = '0; r_vprev = '0; r_prev_v = 0; r_prev_ca = 0;
        r_ack_drv = 0; r_sched = 0; r_cnt = 0; r_cur = 0; r_last = N - 1;
        r_issued = 0; r_acked = 0;
        for (int cyc = 0; cyc < 1700; cyc++) begin
            // A downstream ack consumed on the last edge returns to the channel being served.
            r_exp_ca = r_ack_drv ? N'(1) << r_cur : '0;
            // Valid: held until acked; raised one cycle after an idle edge sees any request.
            if (r_prev_v) r_exp_v = !r_ack_drv;
            else          r_exp_v = !r_prev_ca && (r_vprev != '0);
            check("rand ch_ack", ch_ack_o[0], r_exp_ca);
            check("rand valid", dp_valid[0], r_exp_v);
            if (r_exp_v && !r_prev_v) begin
                r_found = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!r_found && r_vprev[(r_last + k) % N]) begin
                        r_found = 1;
                        r_cur   = (r_last + k) % N;
                    end
                end
                check("rand grant", grant_o[0], r_cur);
                check("rand addr", dp_addr[0], r_pa[r_cur]);
                check("rand data_0", dp_d0[0], r_pd[r_cur][0]);
                check("rand data_1", dp_d1[0], r_pd[r_cur][1]);
                check("rand data_2", dp_d2[0], r_pd[r_cur][2]);
                check("rand data_3", dp_d3[0], r_pd[r_cur][3]);
            end
            if (r_exp_ca != '0) r_last = r_cur;
            r_prev_v  = r_exp_v;
            r_prev_ca = (r_exp_ca != '0);

            // Requesters react to the acks the DUT actually returns.
            for (int ch = 0; ch < N; ch++) begin
                if (ch_ack_o[0][ch] && r_vld[ch]) begin
                    r_vld[ch] = 1'b0;
                    r_acked++;
                end
            end

            r_ack_drv = 0;
            if (r_exp_v) begin
                if (!r_sched) begin
                    r_sched = 1;
                    r_cnt   = $urandom_range(0, 2);
                end
                if (r_cnt == 0) begin
                    r_ack_drv = 1;
                    r_sched   = 0;
                end else begin
                    r_cnt--;
                end
            end

            if (cyc < 1500) begin
                for (int ch = 0; ch < N; ch++) begin
                    if (!r_vld[ch] && $urandom_range(0, 3) == 0) begin
                        r_vld[ch] = 1'b1;
                        r_pa[ch]  = 16'($urandom);
                        for (int w = 0; w < 4; w++) r_pd[ch][w] = {$urandom, $urandom};
                        load(ch, r_pa[ch], r_pd[ch][0], r_pd[ch][1], r_pd[ch][2], r_pd[ch][3]);
                        r_issued++;
                    end
                end
            end

            drv_valid = r_vld;
            r_vprev   = r_vld;
            dp_ack[0] = r_ack_drv;
            tick();
        end
        check("rand all requests acked", r_acked, r_issued);
        check("rand nothing pending", drv_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
